// File: rtl/eviction_write_buffer_if.sv
// Upstream line port (arbiter side) and physical-memory port of the eviction write buffer.
`timescale 1ns/1ps
interface eviction_write_buffer_if;
    logic         mem_read;
    logic         mem_write;
    logic [15:0]  mem_address;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    // Environment view: drives upstream requests and models physical memory.
    modport master (
        output mem_read, mem_write, mem_address, mem_wdata, pmem_rdata, pmem_resp,
        input  mem_rdata, mem_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata, pmem_rdata, pmem_resp,
        output mem_rdata, mem_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/eviction_write_buffer.sv
// Line-granular posted write buffer between the mp3 arbiter and physical memory.
// Define EWB_READ_FORWARD_EN to serve read hits from the buffer instead of draining first.
`timescale 1ns/1ps
module eviction_write_buffer #(
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned DRAIN_DELAY = 4
) (
    input logic                    clk,
    input logic                    rst,
    eviction_write_buffer_if.slave bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned IW = $clog2(DRAIN_DELAY + 1);

    typedef enum logic [2:0] {StIdle, StAck, StRdMiss, StRdAck, StDrain} state_e;
    typedef enum logic [2:0] {ActNone, ActRdHit, ActRdMiss, ActWrHit, ActWrNew, ActDrain} act_e;

    state_e         state_q;
    logic [AW-1:0]  head_q, tail_q;
    logic [CW-1:0]  count_q;
    logic [IW-1:0]  idle_cnt_q;
    logic [11:0]    line_addr_q [DEPTH];
    logic [127:0]   data_q      [DEPTH];
    logic [127:0]   mem_rdata_q, pmem_wdata_q;
    logic [15:0]    pmem_address_q;
    logic           mem_resp_q, pmem_read_q, pmem_write_q;

    logic           hit;
    logic [AW-1:0]  hit_idx, off;
    act_e           act;
    logic           unused_addr_bits;

    assign unused_addr_bits = ^bus.mem_address[3:0];

    // Only occupied slots (offset from head below count) may match.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        off     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            off = AW'(i) - head_q;
            if (CW'(off) < count_q && line_addr_q[i] == bus.mem_address[15:4]) begin
                hit     = 1'b1;
                hit_idx = AW'(i);
            end
        end
    end

    always_comb begin
        act = ActNone;
        if (bus.mem_read) begin
`ifdef EWB_READ_FORWARD_EN
            act = hit ? ActRdHit : ActRdMiss;
`else
            // Flush until the aliasing line is in pmem, then read it as a miss.
            act = hit ? ActDrain : ActRdMiss;
`endif
        end else if (bus.mem_write) begin
            if (hit)                            act = ActWrHit;
            else if (count_q != CW'(DEPTH))     act = ActWrNew;
            else                                act = ActDrain;
        end else if (count_q != '0 && idle_cnt_q >= IW'(DRAIN_DELAY - 1)) begin
            act = ActDrain;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            idle_cnt_q     <= '0;
            mem_rdata_q    <= '0;
            mem_resp_q     <= 1'b0;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                line_addr_q[i] <= '0;
                data_q[i]      <= '0;
            end
        end else begin
            mem_resp_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    idle_cnt_q <= '0;
                    unique case (act)
                        ActNone: begin
                            if (idle_cnt_q != IW'(DRAIN_DELAY)) idle_cnt_q <= idle_cnt_q + 1'b1;
                        end
                        ActRdHit: begin
                            mem_rdata_q <= data_q[hit_idx];
                            mem_resp_q  <= 1'b1;
                            state_q     <= StAck;
                        end
                        ActRdMiss: begin
                            pmem_read_q    <= 1'b1;
                            pmem_address_q <= {bus.mem_address[15:4], 4'h0};
                            state_q        <= StRdMiss;
                        end
                        ActWrHit: begin
                            data_q[hit_idx] <= bus.mem_wdata;
                            mem_resp_q      <= 1'b1;
                            state_q         <= StAck;
                        end
                        ActWrNew: begin
                            line_addr_q[tail_q] <= bus.mem_address[15:4];
                            data_q[tail_q]      <= bus.mem_wdata;
                            tail_q              <= tail_q + 1'b1;
                            count_q             <= count_q + 1'b1;
                            mem_resp_q          <= 1'b1;
                            state_q             <= StAck;
                        end
                        ActDrain: begin
                            pmem_write_q   <= 1'b1;
                            pmem_address_q <= {line_addr_q[head_q], 4'h0};
                            pmem_wdata_q   <= data_q[head_q];
                            state_q        <= StDrain;
                        end
                        default: ;
                    endcase
                end
                StAck, StRdAck: state_q <= StIdle;
                StRdMiss: begin
                    if (bus.pmem_resp) begin
                        pmem_read_q <= 1'b0;
                        mem_rdata_q <= bus.pmem_rdata;
                        mem_resp_q  <= 1'b1;
                        state_q     <= StRdAck;
                    end
                end
                StDrain: begin
                    if (bus.pmem_resp) begin
                        pmem_write_q <= 1'b0;
                        head_q       <= head_q + 1'b1;
                        count_q      <= count_q - 1'b1;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.mem_rdata    = mem_rdata_q;
    assign bus.mem_resp     = mem_resp_q;
    assign bus.pmem_read    = pmem_read_q;
    assign bus.pmem_write   = pmem_write_q;
    assign bus.pmem_address = pmem_address_q;
    assign bus.pmem_wdata   = pmem_wdata_q;
endmodule

// File: tb/tb_eviction_write_buffer.sv
// Directed self-checking bench for eviction_write_buffer (DEPTH=2, DRAIN_DELAY=4).
`timescale 1ns/1ps
module tb_eviction_write_buffer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    eviction_write_buffer_if bus();

    eviction_write_buffer #(
        .DEPTH       (2),
        .DRAIN_DELAY (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [127:0] D1 = 128'h1111_0001_1111_0002_1111_0003_1111_0004;
    localparam logic [127:0] D2 = 128'h2222_1001_2222_1002_2222_1003_2222_1004;
    localparam logic [127:0] D3 = 128'h3333_2001_3333_2002_3333_2003_3333_2004;
    localparam logic [127:0] D4 = 128'h4444_3001_4444_3002_4444_3003_4444_3004;
    localparam logic [127:0] DA = 128'haaaa_0000_aaaa_0000_aaaa_0000_aaaa_0001;
    localparam logic [127:0] DB = 128'hbbbb_0000_bbbb_0000_bbbb_0000_bbbb_0002;
    localparam logic [127:0] DC = 128'hcccc_0000_cccc_0000_cccc_0000_cccc_0003;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_accepts = 0;
    int acc0;

    always @(posedge clk) if (bus.pmem_write && bus.pmem_resp) wr_accepts <= wr_accepts + 1;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_pmem(input string tag);
        int n = 0;
        while (!(bus.pmem_read || bus.pmem_write) && n < 50) begin
            tick();
            n++;
        end
        chk(tag, 128'(bus.pmem_read | bus.pmem_write), 128'd1);
    endtask

    task automatic serve(input int lat, input logic [127:0] rd);
        repeat (lat) tick();
        bus.pmem_rdata = rd;
        bus.pmem_resp  = 1'b1;
        tick();
        bus.pmem_resp  = 1'b0;
    endtask

    task automatic write_line(input string tag, input logic [15:0] a, input logic [127:0] d);
        bus.mem_write   = 1'b1;
        bus.mem_address = a;
        bus.mem_wdata   = d;
        tick();
        chk(tag, 128'(bus.mem_resp), 128'd1);
        bus.mem_write = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        bus.mem_read = 1'b0;  bus.mem_write = 1'b0;
        bus.mem_address = '0; bus.mem_wdata = '0;
        bus.pmem_rdata = '0;  bus.pmem_resp = 1'b0;
        repeat (2) tick();
        chk("rst mem_resp",     128'(bus.mem_resp), 128'd0);
        chk("rst mem_rdata",    bus.mem_rdata, 128'd0);
        chk("rst pmem_read",    128'(bus.pmem_read), 128'd0);
        chk("rst pmem_write",   128'(bus.pmem_write), 128'd0);
        chk("rst pmem_address", 128'(bus.pmem_address), 128'd0);
        chk("rst count",        128'(dut.count_q), 128'd0);
        rst = 1'b0;
        tick();

        // Single write, ack one cycle after request, drain after 4 idle cycles.
        bus.mem_write = 1'b1; bus.mem_address = 16'h1236; bus.mem_wdata = D1;
        tick();
        chk("t2 ack", 128'(bus.mem_resp), 128'd1);
        bus.mem_write = 1'b0;
        tick();
        chk("t2 ack single pulse", 128'(bus.mem_resp), 128'd0);
        repeat (3) tick();
        chk("t2 no early drain", 128'(bus.pmem_write), 128'd0);
        tick();
        chk("t2 drain start", 128'(bus.pmem_write), 128'd1);
        chk("t2 drain addr",  128'(bus.pmem_address), 128'h1230);
        chk("t2 drain data",  bus.pmem_wdata, D1);
        chk("t2 no pmem_read", 128'(bus.pmem_read), 128'd0);
        serve(2, '0);
        chk("t2 write dropped", 128'(bus.pmem_write), 128'd0);
        chk("t2 count", 128'(dut.count_q), 128'd0);

        // Coalescing writes to the same line.
        write_line("t3 ack1", 16'h2008, D1);
        write_line("t3 ack2", 16'h200C, D2);
        chk("t3 count", 128'(dut.count_q), 128'd1);
        acc0 = wr_accepts;
        wait_pmem("t3 drain seen");
        chk("t3 drain addr", 128'(bus.pmem_address), 128'h2000);
        chk("t3 drain data", bus.pmem_wdata, D2);
        serve(1, '0);
        repeat (8) tick();
        chk("t3 single pmem write", 128'(wr_accepts - acc0), 128'd1);
        chk("t3 count end", 128'(dut.count_q), 128'd0);

        // Full buffer: third write forces a drain of the oldest line.
        write_line("t4 ack1", 16'h1000, DA);
        write_line("t4 ack2", 16'h2000, DB);
        chk("t4 full", 128'(dut.count_q), 128'd2);
        bus.mem_write = 1'b1; bus.mem_address = 16'h3000; bus.mem_wdata = DC;
        tick();
        chk("t4 forced drain", 128'(bus.pmem_write), 128'd1);
        chk("t4 forced addr",  128'(bus.pmem_address), 128'h1000);
        chk("t4 forced data",  bus.pmem_wdata, DA);
        chk("t4 no early ack", 128'(bus.mem_resp), 128'd0);
        serve(2, '0);
        chk("t4 ack not yet", 128'(bus.mem_resp), 128'd0);
        tick();
        chk("t4 ack 2 after pmem_resp", 128'(bus.mem_resp), 128'd1);
        bus.mem_write = 1'b0;
        tick();
        chk("t4 count after", 128'(dut.count_q), 128'd2);
        wait_pmem("t4 drain2 seen");
        chk("t4 drain2 addr", 128'(bus.pmem_address), 128'h2000);
        chk("t4 drain2 data", bus.pmem_wdata, DB);
        serve(0, '0);
        wait_pmem("t4 drain3 seen");
        chk("t4 drain3 addr", 128'(bus.pmem_address), 128'h3000);
        chk("t4 drain3 data", bus.pmem_wdata, DC);
        serve(0, '0);
        chk("t4 count end", 128'(dut.count_q), 128'd0);

        // Read that hits a buffered line.
        write_line("t5 ack", 16'h4000, D3);
        bus.mem_read = 1'b1; bus.mem_address = 16'h4004;
        tick();
`ifdef EWB_READ_FORWARD_EN
        chk("t5 fwd resp",  128'(bus.mem_resp), 128'd1);
        chk("t5 fwd rdata", bus.mem_rdata, D3);
        chk("t5 fwd no pmem_read", 128'(bus.pmem_read), 128'd0);
        bus.mem_read = 1'b0;
        tick();
        wait_pmem("t5 later drain");
        chk("t5 later drain addr", 128'(bus.pmem_address), 128'h4000);
        serve(0, '0);
`else
        chk("t5 flush write", 128'(bus.pmem_write), 128'd1);
        chk("t5 flush addr",  128'(bus.pmem_address), 128'h4000);
        chk("t5 flush data",  bus.pmem_wdata, D3);
        chk("t5 no early resp", 128'(bus.mem_resp), 128'd0);
        serve(1, '0);
        tick();
        chk("t5 miss read",  128'(bus.pmem_read), 128'd1);
        chk("t5 miss no write", 128'(bus.pmem_write), 128'd0);
        chk("t5 miss addr",  128'(bus.pmem_address), 128'h4000);
        serve(1, D3);
        chk("t5 resp",  128'(bus.mem_resp), 128'd1);
        chk("t5 rdata", bus.mem_rdata, D3);
        bus.mem_read = 1'b0;
        tick();
`endif
        chk("t5 count end", 128'(dut.count_q), 128'd0);

        // Read miss on empty buffer passes through.
        bus.mem_read = 1'b1; bus.mem_address = 16'h5000;
        tick();
        chk("t6 pmem_read", 128'(bus.pmem_read), 128'd1);
        chk("t6 addr", 128'(bus.pmem_address), 128'h5000);
        chk("t6 no write", 128'(bus.pmem_write), 128'd0);
        serve(10, D4);
        chk("t6 resp",  128'(bus.mem_resp), 128'd1);
        chk("t6 rdata", bus.mem_rdata, D4);
        bus.mem_read = 1'b0;
        tick();
        chk("t6 resp pulse", 128'(bus.mem_resp), 128'd0);

        // Read and write together: read wins, nothing is buffered.
        bus.mem_read = 1'b1; bus.mem_write = 1'b1; bus.mem_address = 16'h9000; bus.mem_wdata = D1;
        tick();
        chk("t7 read wins", 128'(bus.pmem_read), 128'd1);
        chk("t7 no write",  128'(bus.pmem_write), 128'd0);
        serve(0, D2);
        chk("t7 rdata", bus.mem_rdata, D2);
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        tick();
        chk("t7 count", 128'(dut.count_q), 128'd0);

        // Reset in the middle of a drain with two lines held.
        write_line("t1 ack1", 16'h6000, DA);
        write_line("t1 ack2", 16'h7000, DB);
        bus.mem_write = 1'b1; bus.mem_address = 16'h8000; bus.mem_wdata = DC;
        tick();
        chk("t1 draining", 128'(bus.pmem_write), 128'd1);
        chk("t1 count 2", 128'(dut.count_q), 128'd2);
        #1 rst = 1'b1;
        #1;
        chk("t1 async pmem_write", 128'(bus.pmem_write), 128'd0);
        chk("t1 async mem_resp",   128'(bus.mem_resp), 128'd0);
        chk("t1 async count",      128'(dut.count_q), 128'd0);
        bus.mem_write = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("t1 quiet", 128'(bus.pmem_read | bus.pmem_write), 128'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
